ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 199 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and key-state decoder.
// Receives 11-bit PS/2 frames, abandons a stalled frame after TIMEOUT_CYC
// idle clk cycles, and tracks the held state of W, S, J and SPACE from
// make (plain scan code) and break (0xF0 prefix) sequences. Extended-prefixed
// (0xE0) codes never change a key.
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, frames whose data
// plus parity bits have even weight are rejected; otherwise parity is ignored.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       bt_W,
  output logic       bt_S,
  output logic       bt_J,
  output logic       bt_SPACE,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned   IW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] TO_MAX  = IW'(TIMEOUT_CYC);
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_S     = 8'h1B;
  localparam logic [7:0] CODE_J     = 8'h3B;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  // Synchronisers idle high so reset release never looks like a falling edge.
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;

  logic [1:0]    r_state;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_stop;
  logic [IW-1:0] r_idle;
  logic          r_brk;
  logic          r_ext;

  logic r_bt_w, r_bt_s, r_bt_j, r_bt_space;
  logic [7:0] r_key_code;
  logic r_key_valid, r_frame_err;

  logic w_edge;
  logic w_bit;
  logic w_timeout;
  logic w_accept;
  logic w_unused_par;

  // Two-flop synchronisers plus the previous-cycle copy of the ps2_clk sync.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, exactly like real hardware.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_edge    = r_clk_prev & ~r_clk_s2;
  assign w_bit     = r_dat_s2;
  // An edge in the same cycle always beats the timeout.
  assign w_timeout = (r_state == S_RECV) && !w_edge && (r_idle == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
  assign w_accept = r_stop & (^{r_shift, r_par});
`else
  assign w_accept = r_stop;
`endif
  assign w_unused_par = r_par;

  // Inactivity counter: cleared by every edge, saturating at TIMEOUT_CYC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idle <= '0;
    end else if (w_edge) begin
      r_idle <= '0;
    end else if (r_idle != TO_MAX) begin
      r_idle <= r_idle + IW'(1);
    end
  end

  // Frame receiver FSM: start bit, 8 data bits LSB first, parity, stop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_edge && !w_bit) begin
            r_state   <= S_RECV;
            r_bit_cnt <= 4'd1;
          end
        end
        S_RECV: begin
          if (w_edge) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt <= 4'd8) begin
              r_shift <= {w_bit, r_shift[7:1]};
            end else if (r_bit_cnt == 4'd9) begin
              r_par <= w_bit;
            end else begin
              r_stop  <= w_bit;
              r_state <= S_DONE;
            end
          end else if (w_timeout) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_bit_cnt <= 4'd0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_bit_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Byte decoder: prefix flags, key levels, key_code and the status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_bt_w      <= 1'b0;
      r_bt_s      <= 1'b0;
      r_bt_j      <= 1'b0;
      r_bt_space  <= 1'b0;
      r_key_code  <= 8'h00;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= w_timeout;
      if (r_state == S_DONE) begin
        if (!w_accept) begin
          r_frame_err <= 1'b1;
        end else begin
          r_key_code  <= r_shift;
          r_key_valid <= 1'b1;
          if (r_shift == CODE_BREAK) begin
            r_brk <= 1'b1;
          end else if (r_shift == CODE_EXT) begin
            r_ext <= 1'b1;
          end else begin
            if (!r_ext) begin
              case (r_shift)
                CODE_W:     r_bt_w     <= !r_brk;
                CODE_S:     r_bt_s     <= !r_brk;
                CODE_J:     r_bt_j     <= !r_brk;
                CODE_SPACE: r_bt_space <= !r_brk;
                default:    ;
              endcase
            end
            r_brk <= 1'b0;
            r_ext <= 1'b0;
          end
        end
      end
    end
  end

  assign bt_W      = r_bt_w;
  assign bt_S      = r_bt_s;
  assign bt_J      = r_bt_j;
  assign bt_SPACE  = r_bt_space;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by
// random byte streams, compared against a key-table model of the decoder.
module tb_ps2_key_decoder;

  localparam int unsigned TO = 40;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       bt_W, bt_S, bt_J, bt_SPACE;
  logic [7:0] key_code;
  logic       key_valid, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;

  // Reference model: held state per scan code plus prefix flags.
  bit       m_held [256];
  bit       m_brk, m_ext;
  bit [7:0] m_code;

  ps2_key_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .bt_W(bt_W), .bt_S(bt_S), .bt_J(bt_J), .bt_SPACE(bt_SPACE),
    .key_code(key_code), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_code = 8'h00;
  endtask

  task automatic model_byte(input bit [7:0] b);
    m_code = b;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext && (b == 8'h1D || b == 8'h1B || b == 8'h3B || b == 8'h29))
        m_held[b] = !m_brk;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".W"},     bt_W,     m_held[8'h1D]);
    check({tag, ".S"},     bt_S,     m_held[8'h1B]);
    check({tag, ".J"},     bt_J,     m_held[8'h3B]);
    check({tag, ".SPACE"}, bt_SPACE, m_held[8'h29]);
    check({tag, ".code"},  key_code, m_code);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(3);
    ps2_clk = 1'b0;
    tick(6);
    ps2_clk = 1'b1;
    tick(3);
  endtask

  // Full frame with exact latency check of the status pulse on the stop edge.
  task automatic send_frame(input string tag, input logic [7:0] b,
                            input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bit acc;
    int v0, e0;
    bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
    acc  = !bad_stop && (!bad_par || !PAR_EN);
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    ps2_data = bits[10];
    tick(3);
    ps2_clk = 1'b0;
    tick(3);
    @(negedge clk);
    check({tag, ".early_valid"}, key_valid, 1'b0);
    tick(1);
    @(negedge clk);
    check({tag, ".valid"}, key_valid, acc);
    check({tag, ".ferr"},  frame_err, !acc);
    if (acc) model_byte(b);
    check_outputs(tag);
    tick(2);
    ps2_clk = 1'b1;
    tick(8);
    check({tag, ".nvalid"}, n_valid - v0, acc ? 1 : 0);
    check({tag, ".nerr"},   n_err - e0,   acc ? 0 : 1);
  endtask

  initial begin
    int v0, e0;
    bit [7:0] b;
    model_reset();
    tick(3);
    check_outputs("reset");
    check("reset.valid", key_valid, 1'b0);
    check("reset.ferr",  frame_err, 1'b0);
    rstn = 1'b1;
    tick(5);

    // Single make code for W
    send_frame("w_make", 8'h1D, 1'b0, 1'b0);
    // Make, break prefix, break code
    send_frame("w_brk0", 8'hF0, 1'b0, 1'b0);
    send_frame("w_brk1", 8'h1D, 1'b0, 1'b0);
    // Extended SPACE is ignored, plain SPACE follows
    send_frame("ext0", 8'hE0, 1'b0, 1'b0);
    send_frame("ext1", 8'h29, 1'b0, 1'b0);
    send_frame("space", 8'h29, 1'b0, 1'b0);
    send_frame("space_rpt", 8'h29, 1'b0, 1'b0);

    // Partial frame abandoned by the inactivity timeout
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick(TO + 20);
    check("timeout.nerr",   n_err - e0,   1);
    check("timeout.nvalid", n_valid - v0, 0);
    check_outputs("timeout");
    send_frame("j_make", 8'h3B, 1'b0, 1'b0);

    // Wrong parity on S
    send_frame("s_badpar", 8'h1B, 1'b1, 1'b0);
    // Bad stop bit is always rejected
    send_frame("badstop", 8'h3B ^ 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a frame while S is held
    send_frame("s_make", 8'h1B, 1'b0, 1'b0);
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    tick(2);
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    check("midrst.valid", key_valid, 1'b0);
    check("midrst.ferr",  frame_err, 1'b0);
    ps2_clk = 1'b1;
    tick(4);
    rstn = 1'b1;
    tick(TO + 20);
    check("midrst.nvalid", n_valid - v0, 0);
    check("midrst.nerr",   n_err - e0,   0);
    send_frame("s_after", 8'h1B, 1'b0, 1'b0);

    // Random byte streams biased toward mapped keys and prefixes
    for (int k = 0; k < 50; k++) begin
      case ($urandom_range(0, 7))
        0: b = 8'h1D;
        1: b = 8'h1B;
        2: b = 8'h3B;
        3: b = 8'h29;
        4: b = 8'hF0;
        5: b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame("rand", b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
